// File: rtl/trap_controller.sv
// Trap sequencer for the RV32I core: on an exception it writes mepc and
// mcause, reads mtvec and redirects the PC; on MRET it reads mepc and
// redirects. One CSR access per cycle; the core is stalled throughout.
module trap_controller #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      trap_status,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] csr_read_data,
    output logic [11:0]     csr_read_address,
    output logic            csr_write_enable,
    output logic [11:0]     csr_write_address,
    output logic [XLEN-1:0] csr_write_data,
    output logic            trap_busy,
    output logic            trap_redirect,
    output logic [XLEN-1:0] trap_target
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WRITE_MEPC   = 3'd1,
        S_WRITE_MCAUSE = 3'd2,
        S_READ_MTVEC   = 3'd3,
        S_READ_MEPC    = 3'd4,
        S_REDIRECT     = 3'd5
    } state_t;

    localparam logic [2:0]      CODE_MRET  = 3'd6;
    // Direct-mode vectoring: the two low bits of mtvec/mepc are dropped.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Map a latched trap code onto its mcause exception code.
    function automatic logic [XLEN-1:0] cause_code(input logic [2:0] code);
        logic [3:0] c;
        case (code)
            3'd1:    c = 4'd11;
            3'd2:    c = 4'd3;
            3'd3:    c = 4'd0;
            3'd4:    c = 4'd4;
            3'd5:    c = 4'd6;
            default: c = 4'd0;
        endcase
        return {{(XLEN-4){1'b0}}, c};
    endfunction

    state_t            state_q, state_d;
    logic [XLEN-1:0]   saved_pc_q, saved_pc_d;
    logic [2:0]        cause_q, cause_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              csr_we_q, csr_we_d;
    logic [11:0]       csr_waddr_q, csr_waddr_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
    logic [11:0]       csr_raddr_q, csr_raddr_d;
    logic              redirect_q, redirect_d;
    logic              trap_req_s;

    // Codes 1..6 are real requests; 0 and the reserved 7 are ignored.
    assign trap_req_s = (trap_status != 3'd0) && (trap_status != 3'd7);

    // Next-state logic and data capture for the sequencer.
    always_comb begin
        state_d    = state_q;
        saved_pc_d = saved_pc_q;
        cause_d    = cause_q;
        target_d   = target_q;
        case (state_q)
            S_IDLE: begin
                if (trap_req_s) begin
                    saved_pc_d = pc;
                    cause_d    = trap_status;
                    if (trap_status == CODE_MRET) begin
                        state_d = S_READ_MEPC;
                    end else begin
                        state_d = S_WRITE_MEPC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE_MEPC:   state_d = S_WRITE_MCAUSE;
            S_WRITE_MCAUSE: state_d = S_READ_MTVEC;
            S_READ_MTVEC: begin
                target_d = csr_read_data & ALIGN_MASK;
                state_d  = S_REDIRECT;
            end
            S_READ_MEPC: begin
                target_d = csr_read_data & ALIGN_MASK;
                state_d  = S_REDIRECT;
            end
            S_REDIRECT:     state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered strobes line up with the state they belong to.
    always_comb begin
        csr_we_d    = 1'b0;
        csr_waddr_d = 12'h000;
        csr_wdata_d = {XLEN{1'b0}};
        csr_raddr_d = 12'h000;
        redirect_d  = 1'b0;
        case (state_d)
            S_WRITE_MEPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = MEPC_ADDR;
                csr_wdata_d = saved_pc_d;
            end
            S_WRITE_MCAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = MCAUSE_ADDR;
                csr_wdata_d = cause_code(cause_d);
            end
            S_READ_MTVEC: csr_raddr_d = MTVEC_ADDR;
            S_READ_MEPC:  csr_raddr_d = MEPC_ADDR;
            S_REDIRECT:   redirect_d  = 1'b1;
            default:      redirect_d  = 1'b0;
        endcase
    end

    // State, captured data and registered outputs, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            saved_pc_q  <= {XLEN{1'b0}};
            cause_q     <= 3'd0;
            target_q    <= {XLEN{1'b0}};
            csr_we_q    <= 1'b0;
            csr_waddr_q <= 12'h000;
            csr_wdata_q <= {XLEN{1'b0}};
            csr_raddr_q <= 12'h000;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_pc_q  <= saved_pc_d;
            cause_q     <= cause_d;
            target_q    <= target_d;
            csr_we_q    <= csr_we_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            csr_raddr_q <= csr_raddr_d;
            redirect_q  <= redirect_d;
        end
    end

    assign csr_write_enable  = csr_we_q;
    assign csr_write_address = csr_waddr_q;
    assign csr_write_data    = csr_wdata_q;
    assign csr_read_address  = csr_raddr_q;
    assign trap_redirect     = redirect_q;
    assign trap_target       = target_q;
    // Stall includes the accept cycle itself so the trapping instruction
    // never retires.
    assign trap_busy         = (state_q != S_IDLE) || trap_req_s;

endmodule
